// File: rtl/instr_mem_pipe.sv
// Instruction memory slave for the fetch stage (req/gnt/rvalid bus).
// The word is read when the request is accepted. It then passes through a
// fixed-length valid/data pipeline, so several fetches can be in flight and
// responses come back strictly in order. The block also provides:
//   - optional periodic grant suppression, for stressing the fetch unit
//   - an error flag for misaligned or out-of-range addresses
//   - a synchronous load port for writing program contents
module instr_mem_pipe #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int DEPTH           = 8192,
    parameter int READ_LATENCY    = 1,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STALL_PERIOD    = 0,
    localparam int IDX_W          = $clog2(DEPTH)
) (
    input  logic                  req,
    input  logic                  reset,
    input  logic                  instr_req_in,
    input  logic [ADDR_WIDTH-1:0] instr_addr_in,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rinstr_o,
    output logic                  instr_err_o,
    input  logic                  load_we_in,
    input  logic [IDX_W-1:0]      load_addr_in,
    input  logic [DATA_WIDTH-1:0] load_data_in
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int WIDX_W = ADDR_WIDTH - 2;

    // Reject unsupported configurations at elaboration time.
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $fatal(1, "instr_mem_pipe: READ_LATENCY must be within 1..4");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > READ_LATENCY + 1) begin : g_bad_outstanding
        $fatal(1, "instr_mem_pipe: MAX_OUTSTANDING must be within 1..READ_LATENCY+1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [WIDX_W-1:0]     word_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  addr_err;
    logic                  stall_slot;
    logic                  accept;
    logic                  resp_c;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Stage 1 captures the word at the accept edge. The last stage drives
    // the outputs. A data stage only loads when a valid response reaches it,
    // so the output word holds between responses.
    logic [READ_LATENCY:1]                 vld_pipe_q;
    logic [READ_LATENCY:1]                 err_pipe_q;
    logic [READ_LATENCY:1][DATA_WIDTH-1:0] data_pipe_q;

    // Decode the byte address into a word index and flag misaligned or out-of-range accesses.
    always_comb begin
        word_idx = instr_addr_in[ADDR_WIDTH-1:2];
        rd_idx   = word_idx[IDX_W-1:0];
        addr_err = (instr_addr_in[1:0] != 2'b00) | (64'(word_idx) >= 64'(DEPTH));
    end

    // Grant logic. A load, a full outstanding window, a stall slot or reset blocks the request.
    always_comb begin
        instr_gnt_o = instr_req_in & ~reset & ~load_we_in & ~stall_slot
                    & (cnt_q < CNT_W'(MAX_OUTSTANDING));
        accept      = instr_gnt_o;
    end

    if (STALL_PERIOD > 0) begin : g_stall
        localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
        logic [SW-1:0] scnt_q, scnt_d;

        // The free-running slot counter wraps at STALL_PERIOD-1. It advances every cycle.
        always_comb begin
            scnt_d = (scnt_q == SW'(STALL_PERIOD - 1)) ? '0 : scnt_q + 1'b1;
        end

        // Register the stall slot counter.
        always_ff @(posedge req) begin
            if (reset) scnt_q <= '0;
            else       scnt_q <= scnt_d;
        end

        assign stall_slot = (scnt_q == SW'(STALL_PERIOD - 1));
    end else begin : g_no_stall
        assign stall_slot = 1'b0;
    end

    // A response retires on the edge that loads it into the output stage.
    // With a single stage, that edge is the accept edge itself.
    if (READ_LATENCY == 1) begin : g_resp_direct
        assign resp_c = accept;
    end else begin : g_resp_piped
        assign resp_c = vld_pipe_q[READ_LATENCY-1];
    end

    // Count the requests that are accepted but not yet answered.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !resp_c)      cnt_d = cnt_q + 1'b1;
        else if (!accept && resp_c) cnt_d = cnt_q - 1'b1;
    end

    // Register the outstanding counter.
    always_ff @(posedge req) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Read at accept, then shift responses towards the output. Reset drops everything in flight.
    always_ff @(posedge req) begin
        if (reset) begin
            vld_pipe_q  <= '0;
            err_pipe_q  <= '0;
            data_pipe_q <= '0;
        end else begin
            vld_pipe_q[1] <= accept;
            err_pipe_q[1] <= accept & addr_err;
            if (accept) data_pipe_q[1] <= addr_err ? '0 : mem_q[rd_idx];
            for (int k = 2; k <= READ_LATENCY; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                err_pipe_q[k] <= vld_pipe_q[k-1] & err_pipe_q[k-1];
                if (vld_pipe_q[k-1]) data_pipe_q[k] <= data_pipe_q[k-1];
            end
        end
    end

    // Load port. Contents are not reset, so a program survives a reset.
    always_ff @(posedge req) begin
        if (load_we_in && (32'(load_addr_in) < DEPTH)) mem_q[load_addr_in] <= load_data_in;
    end

    assign instr_rvalid_o = vld_pipe_q[READ_LATENCY];
    assign instr_err_o    = err_pipe_q[READ_LATENCY];
    assign instr_rinstr_o = data_pipe_q[READ_LATENCY];

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Bench for instr_mem_pipe. Three configurations share one stimulus stream:
//   u0: READ_LATENCY=1, MAX_OUTSTANDING=2, STALL_PERIOD=4
//   u1: READ_LATENCY=3, MAX_OUTSTANDING=2, no stall
//   u2: READ_LATENCY=2, MAX_OUTSTANDING=1, STALL_PERIOD=5
// The reference model keeps a schedule of expected responses keyed by
// cycle, a cycle count since reset for the stall slots, and a copy of
// the memory.
module tb_instr_mem_pipe;
    localparam int N   = 3;
    localparam int DEP = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_in;
    logic [31:0] addr;
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;

    logic [N-1:0] gnt, rv, er;
    logic [31:0]  rd [N];

    always #5 clk = ~clk;

    instr_mem_pipe #(.DEPTH(DEP), .READ_LATENCY(1), .MAX_OUTSTANDING(2), .STALL_PERIOD(4)) u0 (
        .req(clk), .reset(rst), .instr_req_in(req_in), .instr_addr_in(addr),
        .instr_gnt_o(gnt[0]), .instr_rvalid_o(rv[0]), .instr_rinstr_o(rd[0]), .instr_err_o(er[0]),
        .load_we_in(we), .load_addr_in(waddr), .load_data_in(wdata));

    instr_mem_pipe #(.DEPTH(DEP), .READ_LATENCY(3), .MAX_OUTSTANDING(2), .STALL_PERIOD(0)) u1 (
        .req(clk), .reset(rst), .instr_req_in(req_in), .instr_addr_in(addr),
        .instr_gnt_o(gnt[1]), .instr_rvalid_o(rv[1]), .instr_rinstr_o(rd[1]), .instr_err_o(er[1]),
        .load_we_in(we), .load_addr_in(waddr), .load_data_in(wdata));

    instr_mem_pipe #(.DEPTH(DEP), .READ_LATENCY(2), .MAX_OUTSTANDING(1), .STALL_PERIOD(5)) u2 (
        .req(clk), .reset(rst), .instr_req_in(req_in), .instr_addr_in(addr),
        .instr_gnt_o(gnt[2]), .instr_rvalid_o(rv[2]), .instr_rinstr_o(rd[2]), .instr_err_o(er[2]),
        .load_we_in(we), .load_addr_in(waddr), .load_data_in(wdata));

    // Model state
    int          rl [N];
    int          mo [N];
    int          sp [N];
    bit          pv [N][8];
    logic [31:0] pd [N][8];
    bit          pe [N][8];
    int          kcyc [N];
    logic [31:0] last [N];
    bit          gexp [N];
    logic [31:0] mem [DEP];
    int          e;
    int          checks;
    int          errors;
    int          gcount;
    int          rcount;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: drive, check grant before the edge, update model, check response after.
    task automatic cyc(input bit r, input bit rq, input logic [31:0] a,
                       input bit w, input logic [5:0] wa, input logic [31:0] wd);
        int pend;
        int s;
        bit aerr;
        logic [31:0] dat;
        rst = r; req_in = rq; addr = a; we = w; waddr = wa; wdata = wd;
        #3;
        aerr = (a[1:0] != 2'b00) || ((a >> 2) >= DEP);
        dat  = aerr ? 32'h0 : mem[a[7:2]];
        for (int i = 0; i < N; i++) begin
            pend = 0;
            for (int j = 0; j < 8; j++) pend += int'(pv[i][j]);
            gexp[i] = rq && !r && !w && (pend < mo[i]) &&
                      !(sp[i] > 0 && (kcyc[i] % sp[i]) == sp[i] - 1);
            chk($sformatf("gnt u%0d cyc%0d", i, e), 32'(gnt[i]), 32'(gexp[i]));
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (r) begin
                for (int j = 0; j < 8; j++) pv[i][j] = 1'b0;
                kcyc[i] = 0;
                last[i] = 32'h0;
            end else begin
                if (gexp[i]) begin
                    s = (e + rl[i] - 1) % 8;
                    pv[i][s] = 1'b1;
                    pd[i][s] = dat;
                    pe[i][s] = aerr;
                end
                kcyc[i]++;
            end
        end
        if (w) mem[wa] = wd;
        #1;
        s = e % 8;
        for (int i = 0; i < N; i++) begin
            if (pv[i][s]) last[i] = pd[i][s];
            chk($sformatf("rvalid u%0d cyc%0d", i, e), 32'(rv[i]), 32'(pv[i][s]));
            chk($sformatf("rinstr u%0d cyc%0d", i, e), rd[i], last[i]);
            chk($sformatf("err u%0d cyc%0d", i, e), 32'(er[i]), 32'(pv[i][s] && pe[i][s]));
            pv[i][s] = 1'b0;
        end
        e++;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cyc(0, 0, 32'h0, 0, 6'd0, 32'h0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] ra;
        int sel;
        rl = '{1, 3, 2};
        mo = '{2, 2, 1};
        sp = '{4, 0, 5};
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 8; j++) begin pv[i][j] = 1'b0; pd[i][j] = '0; pe[i][j] = 1'b0; end
            kcyc[i] = 0; last[i] = '0; gexp[i] = 1'b0;
        end
        e = 0; checks = 0; errors = 0;

        // Preload the program while in reset.
        for (int idx = 0; idx < DEP; idx++) begin
            v = (idx == 0) ? 32'h00100093 : (idx == 1) ? 32'h00318193 :
                (idx == 5) ? 32'hAAAAAAAA : $urandom;
            cyc(1, 0, 32'h0, 1, 6'(idx), v);
        end
        cyc(1, 0, 32'h0, 0, 6'd0, 32'h0);

        // Two back-to-back fetches. With single-cycle latency the words return in order.
        cyc(0, 1, 32'h0, 0, 6'd0, 32'h0);
        chk("t1 first word", rd[0], 32'h00100093);
        cyc(0, 1, 32'h4, 0, 6'd0, 32'h0);
        chk("t1 second word", rd[0], 32'h00318193);
        idle(4);

        // Hold the request. Outstanding limits throttle the grant.
        for (int c = 0; c < 12; c++) cyc(0, 1, 32'h0, 0, 6'd0, 32'h0);
        idle(4);

        // Misaligned and out-of-range fetches.
        cyc(0, 1, 32'h2, 0, 6'd0, 32'h0);
        idle(3);
        cyc(0, 1, 32'(4 * DEP), 0, 6'd0, 32'h0);
        idle(4);

        // Stall injection from a fresh reset. Grant and response counts must match.
        cyc(1, 0, 32'h0, 0, 6'd0, 32'h0);
        gcount = 0; rcount = 0;
        for (int c = 0; c < 16; c++) begin
            cyc(0, 1, 32'h4, 0, 6'd0, 32'h0);
            gcount += int'(gexp[0]);
            rcount += int'(rv[0]);
        end
        chk("t4 grant count", 32'(gcount), 32'd12);
        chk("t4 resp count", 32'(rcount), 32'(gcount));
        idle(4);

        // A write after an accepted read does not disturb the response in flight.
        cyc(1, 0, 32'h0, 0, 6'd0, 32'h0);
        cyc(0, 1, 32'd20, 0, 6'd0, 32'h0);
        cyc(0, 1, 32'd20, 1, 6'd5, 32'h55555555);
        chk("t5 old data", rd[2], 32'hAAAAAAAA);
        idle(4);
        cyc(0, 1, 32'd20, 0, 6'd0, 32'h0);
        idle(4);
        chk("t5 new data", rd[2], 32'h55555555);

        // Reset while two fetches are in flight drops both responses.
        cyc(0, 1, 32'h0, 0, 6'd0, 32'h0);
        cyc(0, 1, 32'h4, 0, 6'd0, 32'h0);
        cyc(1, 0, 32'h0, 0, 6'd0, 32'h0);
        idle(6);
        cyc(0, 1, 32'h4, 0, 6'd0, 32'h0);
        idle(4);
        chk("t6 after reset", rd[1], 32'h00318193);

        // Random traffic: fetches, loads, bad addresses and occasional resets.
        for (int c = 0; c < 500; c++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       ra = 32'($urandom_range(0, DEP - 1)) * 4;
            else if (sel == 7) ra = 32'($urandom_range(0, DEP - 1)) * 4 + 32'($urandom_range(1, 3));
            else               ra = (32'(DEP) + 32'($urandom_range(0, 100))) * 4;
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), ra,
                ($urandom_range(0, 9) == 0), 6'($urandom_range(0, DEP - 1)), $urandom);
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
